pixel_seq_ctrl: RTL
===================

# pixel_seq_ctrl

Frame sequencer for the image enhancement datapath. On `start` it walks the frame buffer once in raster order and issues one synchronous read per pixel. It presents each returned pixel to the enhancement stage with a valid/ready handshake and per-pixel position flags. It raises `done` after the last pixel is accepted, which releases the BMP writer.

## Interface
Parameters:
- `WIDTH`, 400, pixels per row (≥2)
- `HEIGHT`, 300, rows per frame (≥2)
- `ADDR_W`, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin frame; sampled in IDLE and DONE only
- `abort`  in  1  synchronous cancel; priority over all other inputs
- `rd_en`  out  1  frame-buffer read strobe
- `rd_addr`  out  ADDR_W  read address (raster index)
- `pix_valid`  out  1  memory data for current pixel is on the data bus
- `pix_ready`  in  1  downstream accepts pixel this cycle
- `pix_col`  out  16  column of presented pixel
- `pix_row`  out  16  row of presented pixel
- `pix_eol`  out  1  presented pixel is last in its row
- `pix_last`  out  1  presented pixel is last in the frame
- `busy`  out  1  state is RUN or DRAIN
- `done`  out  1  frame complete; held until restart, abort or reset
- `data_count`  out  32  pixels accepted in the current or most recent frame

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on the cycle the last read (address TOTAL-1) issues.
  - DRAIN → DONE on `pix_valid & pix_ready & pix_last`.
  - DONE → RUN on `start`.
  - Any state → IDLE on `abort`.
- TOTAL = WIDTH*HEIGHT, held in a localparam. Address, column and row counters wrap to 0 at frame start.
- Read issue rule: `rd_en = (state==RUN) & (!pix_valid | pix_ready)`.
- The memory is a 1-cycle synchronous read and holds its output while `rd_en` is low.
- Output register: `pix_valid` next = `rd_en | (pix_valid & !pix_ready)`. This gives a one-entry pipeline with no skid.
- Position tracking:
  - `pix_col`, `pix_row`, `pix_eol` and `pix_last` describe the pixel currently presented, not the address being issued.
  - They are registered alongside `pix_valid` and stay stable while `pix_valid & !pix_ready`.
- `data_count` increments on each accept. It clears to 0 on the IDLE/DONE → RUN transition.
- Start handling:
  - `start` is ignored in RUN and DRAIN.
  - `start` in DONE clears `done` and restarts at address 0.
- Abort handling:
  - `abort` drops `rd_en` and `pix_valid` in the same cycle (combinational gate on outputs) and clears `done`.
  - An abort coinciding with the last accept wins: no `done`. `data_count` keeps the count including that accept.
- Reset values: all outputs 0, state IDLE, all counters 0.

## Timing
- `start` high at cycle 0 (IDLE):
  - RUN, `rd_en=1`, `rd_addr=0` at cycle 1.
  - `pix_valid` for pixel 0 at cycle 2.
- With `pix_ready` held high:
  - Throughput is one pixel per cycle.
  - The last accept is at cycle TOTAL+1 and `done` is high at cycle TOTAL+2.
- With `pix_ready` low:
  - No new read issues.
  - The presented pixel and all flags hold.
  - `rd_addr` holds its last issued value.
- `busy` is registered from state. `done` rises the cycle after the final accept.
- Reset assertion mid-frame clears everything immediately, with no cleanup of in-flight reads.

## Structure
- Shared package `img_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default WIDTH/HEIGHT/ADDR_W constants
  - `bmp_headersize` constant (54) used by the BMP writer
- Sub-module `pixel_addr_gen`:
  - raster address/column/row counters with `clr` and `inc` inputs
  - outputs `at_eol` and `at_last`
  - instantiated once for the issue side
- The presented-pixel flags are a register copy of the `pixel_addr_gen` outputs captured on `rd_en`.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3 (TOTAL=12).
- Reset, then `start` pulse with `pix_ready=1` → `rd_addr` 0..11 on cycles 1..12; `pix_eol` on col 3 of each row; `pix_last` on pixel 11 at cycle 13; `done=1` at cycle 14; `data_count=12`.
- `pix_ready` low on cycles 3–5 → pixel 1 is held with `pix_col=1`, `pix_row=0`; no `rd_en` during the stall; the frame still completes with `data_count=12` and no duplicated or skipped address.
- `abort` at cycle 6 → `pix_valid=0` and `rd_en=0` that cycle; state IDLE; `done` stays 0; a subsequent `start` restarts at `rd_addr=0`.
- `start` pulsed during RUN → ignored, no address restart. `start` in DONE → `done` drops next cycle, new frame begins, `data_count` clears to 0.
- `abort` coincident with the last accept → `done` never asserts; `data_count=12`.
- `reset` asserted mid-frame (asynchronous, between clock edges) → all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image enhancement datapath: sequencer states,
// default frame geometry and the BMP header size used by the writer.
package img_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int DEF_WIDTH      = 400;
    localparam int DEF_HEIGHT     = 300;
    localparam int DEF_ADDR_W     = 17;
    localparam int bmp_headersize = 54;

    function automatic int frame_total(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/pixel_seq_ctrl_if.sv
// Frame-buffer read port plus the presented-pixel handshake towards the
// enhancement stage. The sequencer is the master.
interface pixel_seq_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pix_valid;
    logic              pix_ready;
    logic [15:0]       pix_col;
    logic [15:0]       pix_row;
    logic              pix_eol;
    logic              pix_last;

    modport master (
        output rd_en, rd_addr, pix_valid, pix_col, pix_row, pix_eol, pix_last,
        input  pix_ready
    );

    modport slave (
        input  rd_en, rd_addr, pix_valid, pix_col, pix_row, pix_eol, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pixel_addr_gen.sv
// Raster address/column/row counters. clr rewinds to pixel 0, inc steps to
// the next pixel in raster order.
module pixel_addr_gen
    import img_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       col,
    output logic [15:0]       row,
    output logic              at_eol,
    output logic              at_last
);
    localparam int TOTAL = frame_total(WIDTH, HEIGHT);

    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       col_r;
    logic [15:0]       row_r;

    assign addr    = addr_r;
    assign col     = col_r;
    assign row     = row_r;
    assign at_eol  = (col_r == 16'(WIDTH - 1));
    assign at_last = (addr_r == ADDR_W'(TOTAL - 1));

    // Raster counters; the step after the last pixel rewinds to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= {ADDR_W{1'b0}};
            col_r  <= 16'd0;
            row_r  <= 16'd0;
        end else if (clr) begin
            addr_r <= {ADDR_W{1'b0}};
            col_r  <= 16'd0;
            row_r  <= 16'd0;
        end else if (inc) begin
            if (at_last) begin
                addr_r <= {ADDR_W{1'b0}};
                col_r  <= 16'd0;
                row_r  <= 16'd0;
            end else if (at_eol) begin
                addr_r <= addr_r + ADDR_W'(1);
                col_r  <= 16'd0;
                row_r  <= row_r + 16'd1;
            end else begin
                addr_r <= addr_r + ADDR_W'(1);
                col_r  <= col_r + 16'd1;
                row_r  <= row_r;
            end
        end else begin
            addr_r <= addr_r;
            col_r  <= col_r;
            row_r  <= row_r;
        end
    end
endmodule

// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer: walks the frame buffer once per start in raster order and
// presents each returned pixel with position flags over a valid/ready port.
module pixel_seq_ctrl
    import img_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    pixel_seq_ctrl_if.master        pix,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             data_count
);
    seq_state_e        state_r;
    logic              busy_r;
    logic              done_r;
    logic [31:0]       count_r;
    logic              pix_valid_r;
    logic [15:0]       col_r;
    logic [15:0]       row_r;
    logic              eol_r;
    logic              last_r;
    logic [ADDR_W-1:0] last_addr_r;

    logic [ADDR_W-1:0] gen_addr_s;
    logic [15:0]       gen_col_s;
    logic [15:0]       gen_row_s;
    logic              gen_eol_s;
    logic              gen_last_s;
    logic              rd_en_s;
    logic              start_go_s;
    logic              accept_s;

    assign rd_en_s    = (state_r == ST_RUN) && (!pix_valid_r || pix.pix_ready) && !abort;
    assign start_go_s = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    // Counted even when abort masks pix_valid, so a cancelled last accept still shows.
    assign accept_s   = pix_valid_r && pix.pix_ready;

    pixel_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_issue_gen (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_go_s),
        .inc     (rd_en_s),
        .addr    (gen_addr_s),
        .col     (gen_col_s),
        .row     (gen_row_s),
        .at_eol  (gen_eol_s),
        .at_last (gen_last_s)
    );

    assign pix.rd_en     = rd_en_s;
    assign pix.rd_addr   = rd_en_s ? gen_addr_s : last_addr_r;
    assign pix.pix_valid = pix_valid_r && !abort;
    assign pix.pix_col   = col_r;
    assign pix.pix_row   = row_r;
    assign pix.pix_eol   = eol_r;
    assign pix.pix_last  = last_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign data_count    = count_r;

    // Frame state machine with registered busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rd_en_s && gen_last_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (accept_s && last_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output stage: flags follow the address issued alongside the read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid_r <= 1'b0;
            col_r       <= 16'd0;
            row_r       <= 16'd0;
            eol_r       <= 1'b0;
            last_r      <= 1'b0;
            last_addr_r <= {ADDR_W{1'b0}};
            count_r     <= 32'd0;
        end else begin
            if (abort) begin
                pix_valid_r <= 1'b0;
            end else begin
                pix_valid_r <= rd_en_s || (pix_valid_r && !pix.pix_ready);
            end
            if (rd_en_s) begin
                col_r       <= gen_col_s;
                row_r       <= gen_row_s;
                eol_r       <= gen_eol_s;
                last_r      <= gen_last_s;
                last_addr_r <= gen_addr_s;
            end
            if (start_go_s) begin
                count_r <= 32'd0;
            end else if (accept_s) begin
                count_r <= count_r + 32'd1;
            end
        end
    end
endmodule
